soc_mem_io: RTL and testbench

- Memory/IO slave sitting directly downstream of the FSM CPU core. Consumes its mem_addr/mem_wdata/mem_rstrb/mem_wstrb bus and produces mem_rdata.
- Contains a word-organised RAM with byte write strobes, an LED register and a UART transmitter.
- Serves both instruction fetch and load/store. Read data is registered so it is valid one cycle after the strobe, which matches the core's WAIT→FETCH and BYTE→WAIT_LOADING timing.

---
 rtl/soc_mem_io_pkg.sv | 19 +
 rtl/soc_uart_tx.sv | 117 +++++++++++
 rtl/soc_mem_io.sv | 90 +++++++++
 tb/tb_soc_mem_io.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_io_pkg.sv
// rtl/soc_mem_io_pkg.sv - shared decode constants and UART state type for soc_mem_io
package soc_mem_io_pkg;

  localparam int IO_SEL_BIT = 22;

  localparam logic [1:0] LED_OFF       = 2'd0;
  localparam logic [1:0] UART_DATA_OFF = 2'd1;
  localparam logic [1:0] UART_STAT_OFF = 2'd2;

  localparam int TX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_state_e;

endpackage

// File: rtl/soc_uart_tx.sv
// rtl/soc_uart_tx.sv - 8N1 UART transmitter with baud counter; optional 4-entry TX FIFO
// under SOC_MEM_IO_TX_FIFO_EN
module soc_uart_tx
  import soc_mem_io_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       txd,
  output logic       busy,
  output logic       full
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  uart_state_e   state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick, load, busy_q, txd_nxt, busy_nxt;
  logic [7:0]    load_data;

  assign tick = (baud_cnt == CNT_MAX);

`ifdef SOC_MEM_IO_TX_FIFO_EN
  localparam int PW = $clog2(TX_FIFO_DEPTH);

  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty, push;

  assign fifo_empty = (count == '0);
  assign full       = (count == (PW+1)'(TX_FIFO_DEPTH));
  // Popping at the end of a stop bit chains the next frame with no idle gap.
  assign load       = !fifo_empty && ((state == TX_IDLE) || (state == TX_STOP && tick));
  assign load_data  = fifo_mem[rd_ptr];
  assign push       = wr_en && (!full || load);
  assign busy       = busy_q || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
`else
  assign full      = 1'b0;
  assign load      = wr_en && (state == TX_IDLE);
  assign load_data = wr_data;
  assign busy      = busy_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (load) state_nxt = TX_START;
      TX_START: if (tick) state_nxt = TX_DATA;
      TX_DATA:  if (tick && bit_idx == 3'd7) state_nxt = TX_STOP;
      TX_STOP:  if (tick) state_nxt = load ? TX_START : TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  // Outputs are registered from the next state so txd never glitches.
  always_comb begin
    txd_nxt  = 1'b1;
    busy_nxt = (state_nxt != TX_IDLE);
    case (state_nxt)
      TX_START: txd_nxt = 1'b0;
      TX_DATA:  txd_nxt = (state == TX_DATA && tick) ? shreg[1] : shreg[0];
      default:  txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd      <= 1'b1;
      busy_q   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      txd    <= txd_nxt;
      busy_q <= busy_nxt;
      if (state == TX_IDLE || tick) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      if (load)                          bit_idx <= '0;
      else if (state == TX_DATA && tick) bit_idx <= bit_idx + 1'b1;
      if (load)                          shreg <= load_data;
      else if (state == TX_DATA && tick) shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: rtl/soc_mem_io.sv
// rtl/soc_mem_io.sv - CPU memory/IO slave: word RAM, LED register, UART TX; TX FIFO via
// SOC_MEM_IO_TX_FIFO_EN
module soc_mem_io
  import soc_mem_io_pkg::*;
#(
  parameter int MEM_WORDS   = 1536,
  parameter     INIT_FILE   = "firmware.hex",
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int LED_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  input  logic             mem_rstrb,
  output logic [31:0]      mem_rdata,
  output logic [LED_W-1:0] leds,
  output logic             uart_txd,
  output logic             uart_busy
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int AW  = $clog2(MEM_WORDS);

  logic [31:0]   ram [MEM_WORDS];
  logic          io_sel, in_range, ram_we, led_we, uart_we, uart_full;
  logic [1:0]    io_off;
  logic [19:0]   word_idx;
  logic [AW-1:0] ram_addr;
  logic [31:0]   rd_word;
  logic          unused_addr;

  assign io_sel      = mem_addr[IO_SEL_BIT];
  assign io_off      = mem_addr[3:2];
  assign word_idx    = mem_addr[21:2];
  assign ram_addr    = word_idx[AW-1:0];
  assign in_range    = ({12'd0, word_idx} < 32'(MEM_WORDS));
  assign unused_addr = ^{mem_addr[31:23], mem_addr[1:0]};

  assign ram_we  = (|mem_wstrb) && !io_sel && in_range;
  assign led_we  = mem_wstrb[0] && io_sel && (io_off == LED_OFF);
  assign uart_we = mem_wstrb[0] && io_sel && (io_off == UART_DATA_OFF);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) ram[ram_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (!io_sel) begin
      if (in_range) rd_word = ram[ram_addr];
    end else begin
      case (io_off)
        LED_OFF:       rd_word = 32'(leds);
        UART_STAT_OFF: rd_word = {30'd0, uart_full, uart_busy};
        default:       rd_word = '0;
      endcase
    end
  end

  // Nonblocking RAM read gives read-before-write on a same-cycle store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata <= '0;
      leds      <= '0;
    end else begin
      if (mem_rstrb) mem_rdata <= rd_word;
      if (led_we)    leds      <= mem_wdata[LED_W-1:0];
    end
  end

  soc_uart_tx #(
    .DIV (DIV)
  ) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (uart_we),
    .wr_data (mem_wdata[7:0]),
    .txd     (uart_txd),
    .busy    (uart_busy),
    .full    (uart_full)
  );

endmodule

// File: tb/tb_soc_mem_io.sv
// tb/tb_soc_mem_io.sv - self-checking bench for soc_mem_io (DIV=10)
module tb_soc_mem_io;

  localparam int DIV = 10;
  localparam logic [31:0] A_LED  = 32'h0040_0000;
  localparam logic [31:0] A_UART = 32'h0040_0004;
  localparam logic [31:0] A_STAT = 32'h0040_0008;
  localparam logic [31:0] A_RSV  = 32'h0040_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic [4:0]  leds;
  logic        uart_txd, uart_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];

  soc_mem_io #(
    .MEM_WORDS   (1536),
    .INIT_FILE   (""),
    .CLK_FREQ_HZ (1000),
    .BAUD        (100),
    .LED_W       (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .leds      (leds),
    .uart_txd  (uart_txd),
    .uart_busy (uart_busy)
  );

  always #5 clk = ~clk;

  // Serial receiver: samples mid-bit and collects decoded bytes.
  initial begin
    logic [7:0] b;
    logic       start_ok;
    forever begin
      @(negedge uart_txd);
      if (!rst) begin
        repeat (DIV/2) @(posedge clk);
        #1 start_ok = (uart_txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1 b[i] = uart_txd;
        end
        repeat (DIV) @(posedge clk);
        #1;
        if (!rst) begin
          checks++;
          if (!start_ok || uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL uart_framing start_ok=%0b stop=%0b required start_ok=1 stop=1", start_ok, uart_txd);
          end
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_addr = a; mem_wdata = d; mem_wstrb = s;
    cyc();
    mem_wstrb = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a; mem_rstrb = 1'b1;
    cyc();
    mem_rstrb = 1'b0;
    d = mem_rdata;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (uart_busy && n < budget) begin cyc(); n++; end
    checks++;
    if (uart_busy !== 1'b0) begin
      errors++;
      $display("FAIL uart_idle_timeout busy=%0b required 0", uart_busy);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (mem_rdata !== 32'h0 || leds !== 5'h0 || uart_txd !== 1'b1 || uart_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdata=%h leds=%h txd=%b busy=%b required 0 0 1 0", mem_rdata, leds, uart_txd, uart_busy);
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] d;
    bus_write(32'h100, 32'h1122_3344, 4'hF);
    bus_read(32'h100, d);
    checks++;
    if (d !== 32'h1122_3344) begin errors++; $display("FAIL word_read got %h required 11223344", d); end
    for (int i = 0; i < 5; i++) begin
      mem_addr = $urandom & 32'h0000_0FFC;
      cyc();
      checks++;
      if (mem_rdata !== 32'h1122_3344) begin errors++; $display("FAIL rdata_hold cycle %0d got %h required 11223344", i, mem_rdata); end
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] d;
    bus_write(32'h100, 32'hAAAA_AAAA, 4'b0100);
    bus_read(32'h100, d);
    checks++;
    if (d !== 32'h11AA_3344) begin errors++; $display("FAIL byte_store got %h required 11aa3344", d); end
    bus_write(32'h0, 32'h600D_F00D, 4'hF);
    bus_read(32'h1800, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL oob_read got %h required 0", d); end
    bus_write(32'h1800, 32'hDEAD_BEEF, 4'hF);
    bus_read(32'h0, d);
    checks++;
    if (d !== 32'h600D_F00D) begin errors++; $display("FAIL oob_write_word0 got %h required 600df00d", d); end
    bus_read(32'h100, d);
    checks++;
    if (d !== 32'h11AA_3344) begin errors++; $display("FAIL oob_write_word64 got %h required 11aa3344", d); end
  endtask

  task automatic test_led();
    logic [31:0] d;
    bus_write(A_LED, 32'h0000_001F, 4'b0001);
    checks++;
    if (leds !== 5'h1F) begin errors++; $display("FAIL led_write got %h required 1f", leds); end
    bus_read(A_LED, d);
    checks++;
    if (d !== 32'h1F) begin errors++; $display("FAIL led_read got %h required 1f", d); end
    bus_write(A_LED, 32'h0000_0300, 4'b0010);
    checks++;
    if (leds !== 5'h1F) begin errors++; $display("FAIL led_lane1_ignored got %h required 1f", leds); end
    bus_read(A_RSV, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_read got %h required 0", d); end
    bus_read(A_LED, d);
    bus_read(A_UART, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL uart_data_read got %h required 0", d); end
  endtask

  task automatic test_read_before_write();
    logic [31:0] d;
    bus_write(32'h100, 32'h1, 4'hF);
    mem_addr = 32'h100; mem_wdata = 32'h2; mem_wstrb = 4'hF; mem_rstrb = 1'b1;
    cyc();
    mem_wstrb = '0; mem_rstrb = 1'b0;
    checks++;
    if (mem_rdata !== 32'h1) begin errors++; $display("FAIL rbw_old got %h required 1", mem_rdata); end
    bus_read(32'h100, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL rbw_new got %h required 2", d); end
  endtask

  task automatic test_ram_random();
    logic [31:0] model [64];
    logic [31:0] d, wd, exp_v;
    logic [3:0]  s;
    int idx, op;
    for (int i = 0; i < 64; i++) begin
      model[i] = $urandom;
      bus_write(32'(i) << 2, model[i], 4'hF);
    end
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 63);
      op  = $urandom_range(0, 2);
      wd  = $urandom;
      s   = 4'($urandom_range(1, 15));
      if (op == 0) begin
        bus_write(32'(idx) << 2, wd, s);
      end else begin
        exp_v = model[idx];
        mem_addr = 32'(idx) << 2; mem_wdata = wd; mem_rstrb = 1'b1;
        mem_wstrb = (op == 2) ? s : 4'h0;
        cyc();
        mem_rstrb = 1'b0; mem_wstrb = '0;
        d = mem_rdata;
        checks++;
        if (d !== exp_v) begin errors++; $display("FAIL ram_random op %0d idx %0d got %h required %h", op, idx, d, exp_v); end
      end
      if (op != 1) begin
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic test_uart_55();
    logic [9:0]  fr;
    logic [31:0] d;
    int bad_txd, bad_busy;
    rx_q.delete();
    fr = {1'b1, 8'h55, 1'b0};
    bad_txd = 0; bad_busy = 0;
    bus_write(A_UART, 32'h55, 4'b0001);
    checks++;
    if (uart_busy !== 1'b1) begin errors++; $display("FAIL busy_after_write got %b required 1", uart_busy); end
`ifdef SOC_MEM_IO_TX_FIFO_EN
    cyc();
`endif
    for (int i = 0; i < 10*DIV; i++) begin
      if (uart_txd !== fr[i/DIV]) bad_txd++;
      if (uart_busy !== 1'b1) bad_busy++;
      if (i == 50) begin mem_addr = A_STAT; mem_rstrb = 1'b1; end
      if (i == 51) begin
        mem_rstrb = 1'b0;
        checks++;
        if (mem_rdata !== 32'h1) begin errors++; $display("FAIL status_busy got %h required 1", mem_rdata); end
      end
      cyc();
    end
    checks++;
    if (bad_txd != 0) begin errors++; $display("FAIL txd_sequence_55 bad cycles %0d required 0", bad_txd); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL busy_window bad cycles %0d required 0", bad_busy); end
    checks++;
    if (uart_busy !== 1'b0 || uart_txd !== 1'b1) begin
      errors++; $display("FAIL frame_end busy=%b txd=%b required 0 1", uart_busy, uart_txd);
    end
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL status_idle got %h required 0", d); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++; $display("FAIL rx_55 count %0d required 1 byte 55", rx_q.size());
    end
  endtask

`ifdef SOC_MEM_IO_TX_FIFO_EN
  task automatic test_uart_fifo();
    logic [7:0]  b [6];
    logic [31:0] d;
    int n;
    rx_q.delete();
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) bus_write(A_UART, {24'h0, b[i]}, 4'b0001);
    bus_read(A_STAT, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL fifo_status_full got %h required 3", d); end
    wait_idle(1000, n);
    checks++;
    if (n != 495) begin errors++; $display("FAIL fifo_back_to_back busy tail %0d required 495", n); end
    repeat (10) cyc();
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL fifo_frame_count got %0d required 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== b[i]) begin errors++; $display("FAIL fifo_byte %0d got %h required %h", i, rx_q[i], b[i]); end
      end
    end
  endtask
`else
  task automatic test_uart_drop();
    int n;
    rx_q.delete();
    bus_write(A_UART, 32'h69, 4'b0001);
    repeat (30) cyc();
    bus_write(A_UART, 32'hA5, 4'b0001);
    wait_idle(300, n);
    checks++;
    if (n != 69) begin errors++; $display("FAIL drop_frame_len busy tail %0d required 69", n); end
    repeat (20) cyc();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h69) begin
      errors++; $display("FAIL drop_single_frame count %0d required 1 byte 69", rx_q.size());
    end
  endtask
`endif

  task automatic test_uart_random();
    logic [7:0] sent[$];
    logic [7:0] v;
    int n;
    rx_q.delete();
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom);
      sent.push_back(v);
      bus_write(A_UART, {$urandom, v} >> 0, 4'b0001);
      wait_idle(200, n);
      repeat ($urandom_range(0, 3)) cyc();
    end
    repeat (10) cyc();
    checks++;
    if (rx_q.size() != sent.size()) begin
      errors++; $display("FAIL rand_frame_count got %0d required %0d", rx_q.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        checks++;
        if (rx_q[i] !== sent[i]) begin errors++; $display("FAIL rand_byte %0d got %h required %h", i, rx_q[i], sent[i]); end
      end
    end
  endtask

  task automatic test_reset_async();
    bus_write(A_LED, 32'h0A, 4'b0001);
    bus_write(A_UART, 32'hC3, 4'b0001);
    repeat (35) cyc();
    checks++;
    if (uart_txd !== 1'b0) begin errors++; $display("FAIL mid_frame_txd got %b required 0", uart_txd); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (leds !== 5'h0 || uart_txd !== 1'b1 || uart_busy !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset leds=%h txd=%b busy=%b rdata=%h required 0 1 0 0", leds, uart_txd, uart_busy, mem_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_store();
    test_led();
    test_read_before_write();
    test_ram_random();
    test_uart_55();
`ifdef SOC_MEM_IO_TX_FIFO_EN
    test_uart_fifo();
`else
    test_uart_drop();
`endif
    test_uart_random();
    test_reset_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
